vz16_fetch_queue: RTL and testbench
===================================

Name: vz16_fetch_queue

Overview:
- Instruction fetch queue between the I-cache fetch stage and the dual VZ16 decoders.
- Accepts up to two 16-bit instructions per cycle, each with its PC, and compacts them into a circular buffer.
- Presents the oldest two instructions in program order to decode lanes 0 and 1, and retires whatever decode takes.
- Flush drops all contents on a branch redirect.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  redirect; discards all entries.
- in_valid  input  1  fetch packet present.
- in_mask  input  2  per-slot valid bits of the packet; 2'b00 is a legal empty packet.
- in_inst0  input  16  instruction, slot 0.
- in_inst1  input  16  instruction, slot 1.
- in_pc  input  16  PC of slot 0; slot 1 PC = in_pc + 1, 16-bit wrap.
- in_ready  output  1  queue can accept a full packet.
- out_valid  output  2  decode lane valids; out_valid[1] implies out_valid[0].
- out_inst0  output  16  oldest instruction.
- out_inst1  output  16  second-oldest instruction.
- out_pc0  output  16  PC of out_inst0.
- out_pc1  output  16  PC of out_inst1.
- out_take  input  2  decode consumption; legal values 2'b00, 2'b01, 2'b11.
- occupancy  output  PTR_W+1  current entry count.

Behaviour:
- Storage: DEPTH entries of {inst[15:0], pc[15:0]}, with head pointer, tail pointer and count registers.
- Reset (async, rst_n=0):
  - head=0, tail=0, count=0.
  - out_valid=2'b00, occupancy=0, in_ready=1.
  - Entry contents are don't-care.
- in_ready = (DEPTH - count) >= 2, from registered count only. No credit is given for a same-cycle dequeue, and there is no combinational path from out_take.
- Enqueue fires when in_valid && in_ready && !flush.
  - Slots are written compacted in order slot0, slot1, skipping slots whose mask bit is 0.
  - 2'b10: inst1/pc+1 goes to tail.
  - 2'b01: inst0/pc goes to tail.
  - 2'b11: inst0 to tail, inst1 to tail+1.
  - tail advances by popcount(in_mask), mod DEPTH.
- in_valid while in_ready=0: the packet is ignored, not stored. Fetch must hold it.
- Outputs are combinational from storage at head and head+1 (mod DEPTH).
  - out_valid[0] = count>=1.
  - out_valid[1] = count>=2.
  - Data on an invalid lane is don't-care.
- No bypass: an instruction written at edge N is first visible on out_* after edge N, giving 1-cycle enqueue-to-decode latency.
- Dequeue: on each edge, head advances by popcount(out_take & out_valid).
  - Takes on invalid lanes are ignored.
  - out_take=2'b10 is illegal; assert in simulation, and the RTL treats it as 2'b00.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n. Both pointer updates happen in the same edge.
- Wrap-around: both pointers wrap modulo DEPTH; a two-slot write or read may straddle DEPTH-1 to 0.
- Full: count == DEPTH or DEPTH-1 gives in_ready=0.
- Empty: count == 0 gives out_valid=2'b00.
- Flush (synchronous, highest priority):
  - Next edge sets head=tail=0 and count=0.
  - Same-cycle enqueue and dequeue are discarded.
  - After that edge: out_valid=0, in_ready=1.
- Reset asserted mid-operation clears immediately (asynchronously), regardless of flush, in_valid or out_take.
- Overflow and underflow are structurally impossible; the bench asserts count <= DEPTH.

Test Plan:
- Reset then idle -> out_valid=00, in_ready=1, occupancy=0; with in_valid=0 for 5 cycles, state is unchanged.
- Enqueue mask=11, inst0=16'h1238, inst1=16'h4561, pc=16'h0100, take=00 -> next cycle out_valid=11, out_pc0=0100, out_pc1=0101, occupancy=2.
- Enqueue mask=10, inst1=16'hABC2, pc=16'h0203 -> out_inst0=ABC2, out_pc0=0204, out_valid=01; then take=01 -> out_valid=00.
- With DEPTH=8: fill with four mask=11 packets (take=00) -> occupancy=8, in_ready=0; an extra in_valid packet is dropped; take=11 for 4 cycles drains the FIFO in order with wrap (head 6 -> 0).
- Steady state with mask=11 enqueue and take=11 each cycle -> occupancy stays constant, and PCs leave strictly incrementing across the pointer wrap.
- With occupancy=5, assert flush together with in_valid=1 and take=11 -> next cycle occupancy=0, out_valid=00, and the flushed-cycle packet never appears. Then assert rst_n=0 mid-stream -> outputs clear with no clock edge.

Source files
------------

// File: rtl/vz16_fetch_queue.sv
// rtl/vz16_fetch_queue.sv - dual-issue instruction fetch queue feeding the VZ16 decoders
//
// Compacts up to two 16-bit instructions per cycle into a circular buffer and
// presents the oldest two, in program order, to decode lanes 0 and 1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                redirect; empties the queue on the next edge
//   in_valid, in_mask    fetch packet present, per-slot valid bits
//   in_inst0, in_inst1   slot instructions
//   in_pc                PC of slot 0 (slot 1 is in_pc + 1)
//   in_ready             room for a full two-slot packet
//   out_valid            decode lane valids
//   out_inst0/1, out_pc0/1  oldest and second-oldest entries
//   out_take             decode consumption (00, 01, 11)
//   occupancy            current entry count

module vz16_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_mask,
  input  logic [15:0]      in_inst0,
  input  logic [15:0]      in_inst1,
  input  logic [15:0]      in_pc,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [15:0]      out_inst0,
  output logic [15:0]      out_inst1,
  output logic [15:0]      out_pc0,
  output logic [15:0]      out_pc1,
  input  logic [1:0]       out_take,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 1);

  logic [15:0] mem_inst [DEPTH];
  logic [15:0] mem_pc   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  logic             enq_fire;
  logic [1:0]       enq_n;
  logic             wr0_en;
  logic             wr1_en;
  logic [15:0]      wr0_inst;
  logic [15:0]      wr0_pc;
  logic [15:0]      pc_slot1;

  logic             deq0;
  logic             deq1;
  logic [1:0]       deq_n;

  assign head_p1  = head + PTR_W'(1);
  assign tail_p1  = tail + PTR_W'(1);
  assign pc_slot1 = in_pc + 16'd1;

  // Readiness depends on registered count only; a same-cycle dequeue earns no credit.
  assign in_ready = (count < READY_LIMIT);
  assign enq_fire = in_valid && in_ready && !flush;

  // Compaction: the first written entry is slot 0 unless only slot 1 is valid.
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_inst = in_inst0;
    wr0_pc   = in_pc;
    enq_n    = 2'd0;
    if (enq_fire) begin
      case (in_mask)
        2'b01: begin
          wr0_en = 1'b1;
          enq_n  = 2'd1;
        end
        2'b10: begin
          wr0_en   = 1'b1;
          wr0_inst = in_inst1;
          wr0_pc   = pc_slot1;
          enq_n    = 2'd1;
        end
        2'b11: begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
          enq_n  = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign out_valid[0] = (count != '0);
  assign out_valid[1] = (count > (PTR_W+1)'(1));

  // Lane 1 is taken only alongside lane 0, so an illegal 2'b10 consumes nothing.
  assign deq0  = out_take[0] && out_valid[0];
  assign deq1  = out_take[1] && out_take[0] && out_valid[1];
  assign deq_n = {1'b0, deq0} + {1'b0, deq1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
    end
  end

  // Entry contents need no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_inst[tail] <= wr0_inst;
      mem_pc[tail]   <= wr0_pc;
    end
    if (wr1_en) begin
      mem_inst[tail_p1] <= in_inst1;
      mem_pc[tail_p1]   <= pc_slot1;
    end
  end

  assign out_inst0 = mem_inst[head];
  assign out_pc0   = mem_pc[head];
  assign out_inst1 = mem_inst[head_p1];
  assign out_pc1   = mem_pc[head_p1];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (out_take != 2'b10);
    end
  end

endmodule

// File: tb/tb_vz16_fetch_queue.sv
// tb/tb_vz16_fetch_queue.sv - directed-vector bench for vz16_fetch_queue

module tb_vz16_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [1:0]       in_mask;
  logic [15:0]      in_inst0;
  logic [15:0]      in_inst1;
  logic [15:0]      in_pc;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [15:0]      out_inst0;
  logic [15:0]      out_inst1;
  logic [15:0]      out_pc0;
  logic [15:0]      out_pc1;
  logic [1:0]       out_take;
  logic [PTR_W:0]   occupancy;

  int n_vec;
  int n_err;

  vz16_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_mask   (in_mask),
    .in_inst0  (in_inst0),
    .in_inst1  (in_inst1),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst0 (out_inst0),
    .out_inst1 (out_inst1),
    .out_pc0   (out_pc0),
    .out_pc1   (out_pc1),
    .out_take  (out_take),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] i0,
                       input logic [15:0] i1, input logic [15:0] pc, input logic [1:0] tk);
    in_valid = v;
    in_mask  = m;
    in_inst0 = i0;
    in_inst1 = i1;
    in_pc    = pc;
    out_take = tk;
  endtask

  always @(negedge clk) begin
    if (rst_n) check("occ_bound", 32'(occupancy <= 4'(DEPTH)), 32'd1);
  end

  logic [15:0] exp_pc;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_occ", 32'(occupancy), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_ready", 32'(in_ready), 32'h1);
    check("idle_occ", 32'(occupancy), 32'h0);

    // two-slot packet
    drive(1'b1, 2'b11, 16'h1238, 16'h4561, 16'h0100, 2'b00);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    check("p11_valid", 32'(out_valid), 32'h3);
    check("p11_inst0", 32'(out_inst0), 32'h1238);
    check("p11_inst1", 32'(out_inst1), 32'h4561);
    check("p11_pc0", 32'(out_pc0), 32'h0100);
    check("p11_pc1", 32'(out_pc1), 32'h0101);
    check("p11_occ", 32'(occupancy), 32'h2);
    out_take = 2'b11;
    tick();
    out_take = 2'b00;
    check("p11_drain", 32'(occupancy), 32'h0);

    // slot-1-only packet
    drive(1'b1, 2'b10, 16'hFFFF, 16'hABC2, 16'h0203, 2'b00);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    check("p10_inst0", 32'(out_inst0), 32'hABC2);
    check("p10_pc0", 32'(out_pc0), 32'h0204);
    check("p10_valid", 32'(out_valid), 32'h1);
    out_take = 2'b01;
    tick();
    out_take = 2'b00;
    check("p10_take", 32'(out_valid), 32'h0);

    // slot-0-only packet, then take=11 with one valid lane
    drive(1'b1, 2'b01, 16'h5555, 16'hEEEE, 16'h0300, 2'b00);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    check("p01_inst0", 32'(out_inst0), 32'h5555);
    check("p01_pc0", 32'(out_pc0), 32'h0300);
    check("p01_valid", 32'(out_valid), 32'h1);
    out_take = 2'b11;
    tick();
    out_take = 2'b00;
    check("p01_take11", 32'(occupancy), 32'h0);

    // fill to full, drop an extra packet, drain across the wrap
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 16'hA000 + 16'(2*k), 16'hA001 + 16'(2*k), 16'h1000 + 16'(2*k), 2'b00);
      tick();
      check("fill_occ", 32'(occupancy), 32'(2*k + 2));
      check("fill_ready", 32'(in_ready), (k < 3) ? 32'h1 : 32'h0);
    end
    drive(1'b1, 2'b11, 16'hDEAD, 16'hBEEF, 16'h2000, 2'b00);
    tick();
    check("full_drop_occ", 32'(occupancy), 32'h8);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b11);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc0", 32'(out_pc0), 32'h1000 + 32'(2*k));
      check("drain_pc1", 32'(out_pc1), 32'h1001 + 32'(2*k));
      check("drain_inst0", 32'(out_inst0), 32'hA000 + 32'(2*k));
      check("drain_valid", 32'(out_valid), 32'h3);
      tick();
    end
    out_take = 2'b00;
    check("drain_occ", 32'(occupancy), 32'h0);
    check("drain_ready", 32'(in_ready), 32'h1);

    // steady state: enqueue two, take two each cycle
    drive(1'b1, 2'b11, 16'h7000, 16'h7001, 16'h3000, 2'b00);
    tick();
    exp_pc = 16'h3000;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'b11, 16'h7002 + 16'(2*k), 16'h7003 + 16'(2*k), 16'h3002 + 16'(2*k), 2'b11);
      check("ss_pc0", 32'(out_pc0), 32'(exp_pc));
      check("ss_pc1", 32'(out_pc1), 32'(exp_pc + 16'd1));
      tick();
      exp_pc = exp_pc + 16'd2;
      check("ss_occ", 32'(occupancy), 32'h2);
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b11);
    check("ss_last_pc0", 32'(out_pc0), 32'(exp_pc));
    tick();
    out_take = 2'b00;
    check("ss_empty", 32'(occupancy), 32'h0);

    // occupancy 5, then flush with a concurrent packet and take
    drive(1'b1, 2'b11, 16'h8000, 16'h8001, 16'h4000, 2'b00);
    tick();
    drive(1'b1, 2'b11, 16'h8002, 16'h8003, 16'h4002, 2'b00);
    tick();
    drive(1'b1, 2'b01, 16'h8004, 16'h0000, 16'h4004, 2'b00);
    tick();
    check("pre_flush_occ", 32'(occupancy), 32'h5);
    drive(1'b1, 2'b11, 16'h9000, 16'h9001, 16'h5000, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    check("flush_occ", 32'(occupancy), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_ready", 32'(in_ready), 32'h1);
    tick();
    check("flush_no_ghost", 32'(occupancy), 32'h0);
    drive(1'b1, 2'b11, 16'hC000, 16'hC001, 16'h6000, 2'b00);
    tick();
    check("post_flush_pc0", 32'(out_pc0), 32'h6000);
    check("post_flush_inst1", 32'(out_inst1), 32'hC001);

    // asynchronous reset mid-stream
    drive(1'b1, 2'b11, 16'hC002, 16'hC003, 16'h6002, 2'b01);
    rst_n = 1'b0;
    #1;
    check("arst_occ", 32'(occupancy), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_hold", 32'(occupancy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
